// File: rtl/noc_rr_switch_pkg.sv
// Shared types for the NoC round-robin switch.
// Flit/FSM/port enums and flit-type field position.
package noc_switch_pkg;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    HEAD   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_t;

  typedef enum logic {
    I_IDLE = 1'b0,
    I_ACK  = 1'b1
  } in_state_t;

  typedef enum logic [1:0] {
    O_EMPTY = 2'd0,
    O_REQ   = 2'd1,
    O_WAIT  = 2'd2
  } out_state_t;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    WEST  = 3'd1,
    NORTH = 3'd2,
    EAST  = 3'd3,
    SOUTH = 3'd4
  } port_t;

  // Type field bits, as offsets below the flit's top bit.
  localparam int FLIT_TYPE_MSB = 0;
  localparam int FLIT_TYPE_LSB = 1;

endpackage

// File: rtl/noc_rr_switch_if.sv
// Switch bus: input-side and output-side 4-phase handshakes.
// slave = switch side, master = environment side.
interface noc_rr_switch_if #(
  parameter int DATA_WIDTH = 18,
  parameter int NUM_PORTS  = 5,
  parameter int DEST_WIDTH = $clog2(NUM_PORTS)
);
  logic [NUM_PORTS-1:0]                 in_req;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] in_data;
  logic [NUM_PORTS-1:0][DEST_WIDTH-1:0] in_dest;
  logic [NUM_PORTS-1:0]                 in_ack;
  logic [NUM_PORTS-1:0]                 out_req;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] out_data;
  logic [NUM_PORTS-1:0]                 out_ack;
  logic [NUM_PORTS-1:0]                 out_locked;

  modport master (
    output in_req, in_data, in_dest, out_ack,
    input  in_ack, out_req, out_data, out_locked
  );

  modport slave (
    input  in_req, in_data, in_dest, out_ack,
    output in_ack, out_req, out_data, out_locked
  );
endinterface

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter: first request after i_ptr wins.
// i_req/i_ptr/i_en in, one-hot o_grant and o_valid out.
module noc_rr_arbiter #(
  parameter  int N  = 5,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_grant,
  output logic          o_valid
);
  logic [PW-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = PW'((int'(i_ptr) + k) % N);
      if (i_en && !o_valid && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_valid        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/noc_rr_switch.sv
// Registered NxN crossbar, per-output RR arbiter + holding reg.
// clk/rst_n plain; all channels via noc_rr_switch_if.slave.
module noc_rr_switch
  import noc_switch_pkg::*;
#(
  parameter int DATA_WIDTH   = 18,
  parameter int NUM_PORTS    = 5,
  parameter int DEST_WIDTH   = $clog2(NUM_PORTS),
  parameter int LOCK_PACKETS = 1
) (
  input logic          clk,
  input logic          rst_n,
  noc_rr_switch_if.slave bus
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int TH = DATA_WIDTH - 1 - FLIT_TYPE_MSB;
  localparam int TL = DATA_WIDTH - 1 - FLIT_TYPE_LSB;

  in_state_t             r_in_st  [NUM_PORTS];
  in_state_t             w_in_nxt [NUM_PORTS];
  out_state_t            r_out_st [NUM_PORTS];
  out_state_t            w_out_nxt[NUM_PORTS];
  logic [NUM_PORTS-1:0]  r_lock, w_lock_nxt;
  logic [PW-1:0]         r_own  [NUM_PORTS];
  logic [PW-1:0]         w_own_nxt[NUM_PORTS];
  logic [PW-1:0]         r_ptr  [NUM_PORTS];
  logic [PW-1:0]         w_ptr_nxt[NUM_PORTS];
  logic [DATA_WIDTH-1:0] r_hold [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_hold_nxt[NUM_PORTS];

  logic [NUM_PORTS-1:0]  w_cand [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_gnt  [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_gv;
  logic [NUM_PORTS-1:0]  w_in_gnt;
  logic [PW-1:0]         w_gidx [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_gdat [NUM_PORTS];

  // A locked output only sees its owner.
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      w_cand[j] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        w_cand[j][i] = bus.in_req[i]
                    && (bus.in_dest[i] == DEST_WIDTH'(j))
                    && (r_in_st[i] == I_IDLE)
                    && (!r_lock[j] || r_own[j] == PW'(i));
      end
    end
  end

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_arb
    noc_rr_arbiter #(.N(NUM_PORTS)) u_arb (
      .i_req   (w_cand[j]),
      .i_ptr   (r_ptr[j]),
      .i_en    (r_out_st[j] == O_EMPTY),
      .o_grant (w_gnt[j]),
      .o_valid (w_gv[j])
    );
  end

  always_comb begin
    w_in_gnt = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      w_gidx[j] = '0;
      w_gdat[j] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_gnt[j][i]) begin
          w_gidx[j]   = PW'(i);
          w_gdat[j]   = bus.in_data[i];
          w_in_gnt[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_in_nxt[i] = r_in_st[i];
      case (r_in_st[i])
        I_IDLE:  if (w_in_gnt[i]) w_in_nxt[i] = I_ACK;
        I_ACK:   if (!bus.in_req[i]) w_in_nxt[i] = I_IDLE;
        default: w_in_nxt[i] = I_IDLE;
      endcase
    end
  end

  flit_type_t w_ftype;

  always_comb begin
    w_ftype    = BODY;
    w_lock_nxt = r_lock;
    for (int j = 0; j < NUM_PORTS; j++) begin
      w_out_nxt[j]  = r_out_st[j];
      w_own_nxt[j]  = r_own[j];
      w_ptr_nxt[j]  = r_ptr[j];
      w_hold_nxt[j] = r_hold[j];
      w_ftype       = flit_type_t'(w_gdat[j][TH:TL]);
      case (r_out_st[j])
        O_EMPTY: begin
          if (w_gv[j]) begin
            w_out_nxt[j]  = O_REQ;
            w_hold_nxt[j] = w_gdat[j];
            if (LOCK_PACKETS != 0) begin
              unique case (1'b1)
                (w_ftype == HEAD): begin
                  w_lock_nxt[j] = 1'b1;
                  w_own_nxt[j]  = w_gidx[j];
                end
                (w_ftype == TAIL),
                (w_ftype == SINGLE): w_lock_nxt[j] = 1'b0;
                default: ;
              endcase
            end
            // Pointer only moves once the packet releases j.
            if (!w_lock_nxt[j]) w_ptr_nxt[j] = w_gidx[j];
          end
        end
        O_REQ:   if (bus.out_ack[j])  w_out_nxt[j] = O_WAIT;
        O_WAIT:  if (!bus.out_ack[j]) w_out_nxt[j] = O_EMPTY;
        default: w_out_nxt[j] = O_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_in_st[i]  <= I_IDLE;
        r_out_st[i] <= O_EMPTY;
        r_own[i]    <= '0;
        r_ptr[i]    <= PW'(NUM_PORTS - 1);
        r_hold[i]   <= '0;
      end
    end else begin
      r_lock <= w_lock_nxt;
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_in_st[i]  <= w_in_nxt[i];
        r_out_st[i] <= w_out_nxt[i];
        r_own[i]    <= w_own_nxt[i];
        r_ptr[i]    <= w_ptr_nxt[i];
        r_hold[i]   <= w_hold_nxt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      bus.in_ack[i]     = (r_in_st[i] == I_ACK);
      bus.out_req[i]    = (r_out_st[i] == O_REQ);
      bus.out_data[i]   = r_hold[i];
      bus.out_locked[i] = r_lock[i];
    end
  end
endmodule

// File: tb/tb_noc_rr_switch.sv
// Directed bench for noc_rr_switch, locked and unlocked builds.
// Both instances receive identical stimulus.
module tb_noc_rr_switch;
  localparam int NP  = 5;
  localparam int DW  = 18;
  localparam int DSW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  noc_rr_switch_if #(.DATA_WIDTH(DW), .NUM_PORTS(NP),
                     .DEST_WIDTH(DSW)) bl ();
  noc_rr_switch_if #(.DATA_WIDTH(DW), .NUM_PORTS(NP),
                     .DEST_WIDTH(DSW)) bn ();

  noc_rr_switch #(.DATA_WIDTH(DW), .NUM_PORTS(NP),
                  .DEST_WIDTH(DSW), .LOCK_PACKETS(1))
    dut_l (.clk(clk), .rst_n(rst_n), .bus(bl));
  noc_rr_switch #(.DATA_WIDTH(DW), .NUM_PORTS(NP),
                  .DEST_WIDTH(DSW), .LOCK_PACKETS(0))
    dut_n (.clk(clk), .rst_n(rst_n), .bus(bn));

  logic [NP-1:0]          s_req  [2];
  logic [NP-1:0][DW-1:0]  s_data [2];
  logic [NP-1:0][DSW-1:0] s_dest [2];
  logic [NP-1:0]          s_ack  [2];
  logic [NP-1:0]          o_req  [2];
  logic [NP-1:0]          o_lk   [2];
  logic [NP-1:0][DW-1:0]  o_dat  [2];
  logic [NP-1:0]          o_ack  [2];
  logic                   snk_en;

  assign bl.in_req  = s_req[0];
  assign bl.in_data = s_data[0];
  assign bl.in_dest = s_dest[0];
  assign bl.out_ack = o_ack[0];
  assign bn.in_req  = s_req[1];
  assign bn.in_data = s_data[1];
  assign bn.in_dest = s_dest[1];
  assign bn.out_ack = o_ack[1];
  assign s_ack[0] = bl.in_ack;
  assign s_ack[1] = bn.in_ack;
  assign o_req[0] = bl.out_req;
  assign o_req[1] = bn.out_req;
  assign o_lk[0]  = bl.out_locked;
  assign o_lk[1]  = bn.out_locked;
  assign o_dat[0] = bl.out_data;
  assign o_dat[1] = bn.out_data;

  // Downstream links echo out_req half a cycle later.
  always @(negedge clk) begin
    o_ack[0] = snk_en ? o_req[0] : '0;
    o_ack[1] = snk_en ? o_req[1] : '0;
  end

  // Log every flit presented on an output, with its lock flag.
  logic [DW-1:0] lg_d [2][NP][16];
  logic          lg_k [2][NP][16];
  int            lg_n [2][NP] = '{default: 0};
  logic [NP-1:0] pv   [2] = '{default: '0};

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      for (int j = 0; j < NP; j++) begin
        if (o_req[m][j] === 1'b1 && pv[m][j] !== 1'b1
            && lg_n[m][j] < 16) begin
          lg_d[m][j][lg_n[m][j]] = o_dat[m][j];
          lg_k[m][j][lg_n[m][j]] = o_lk[m][j];
          lg_n[m][j] = lg_n[m][j] + 1;
        end
      end
      pv[m] = o_req[m];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int m, input int p,
                      input logic [DW-1:0] d,
                      input logic [DSW-1:0] dst);
    int t;
    s_data[m][p] = d;
    s_dest[m][p] = dst;
    s_req[m][p]  = 1'b1;
    t = 0;
    while (s_ack[m][p] !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("ack_up_to", 32'(t >= 200), 0);
    s_req[m][p] = 1'b0;
    t = 0;
    while (s_ack[m][p] !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("ack_dn_to", 32'(t >= 200), 0);
  endtask

  task automatic two(input int m, input int p);
    logic [DW-1:0] d;
    d = 18'h30100 + DW'(p * 16);
    send(m, p, d, 3'd1);
    send(m, p, d + 18'h1, 3'd1);
  endtask

  task automatic pkt(input int m);
    send(m, 2, 18'h10200, 3'd0);
    send(m, 2, 18'h00201, 3'd0);
    send(m, 2, 18'h20202, 3'd0);
  endtask

  logic [DW-1:0] e_rr [6];
  logic [DW-1:0] e_wl [4];
  logic          k_wl [4];
  logic [DW-1:0] e_wn [4];
  int b0, b1, d5;

  initial begin
    #200000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  initial begin
    e_rr = '{18'h30100, 18'h30120, 18'h30140,
             18'h30101, 18'h30121, 18'h30141};
    e_wl = '{18'h10200, 18'h00201, 18'h20202, 18'h30400};
    k_wl = '{1'b1, 1'b1, 1'b0, 1'b0};
    e_wn = '{18'h10200, 18'h30400, 18'h00201, 18'h20202};
    for (int m = 0; m < 2; m++) begin
      s_req[m] = '0;
      s_data[m] = '0;
      s_dest[m] = '0;
    end
    snk_en = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_ack", 32'(s_ack[0]), 0);
    chk("rst_req", 32'(o_req[0]), 0);
    chk("rst_lk",  32'(o_lk[1]), 0);
    chk("rst_dat", 32'(o_dat[0][3]), 0);

    // Single flit, input 1 -> output 3.
    fork
      send(0, 1, 18'h300AA, 3'd3);
      send(1, 1, 18'h300AA, 3'd3);
      begin
        @(negedge clk);
        chk("sf_ack", 32'(s_ack[0]), 32'h02);
        chk("sf_req", 32'(o_req[0]), 32'h08);
        chk("sf_dat", 32'(o_dat[0][3]), 32'h300AA);
        chk("sf_lk",  32'(o_lk[0][3]), 0);
      end
    join
    repeat (6) @(negedge clk);

    // Round robin on output 1.
    b0 = lg_n[0][1];
    b1 = lg_n[1][1];
    fork
      two(0, 0); two(0, 2); two(0, 4);
      two(1, 0); two(1, 2); two(1, 4);
    join
    repeat (6) @(negedge clk);
    chk("rr_cnt", 32'(lg_n[0][1] - b0), 6);
    for (int k = 0; k < 6; k++) begin
      chk("rr_l", 32'(lg_d[0][1][(b0 + k) % 16]), 32'(e_rr[k]));
      chk("rr_n", 32'(lg_d[1][1][(b1 + k) % 16]), 32'(e_rr[k]));
    end

    // Wormhole vs. per-flit arbitration on output 0.
    b0 = lg_n[0][0];
    b1 = lg_n[1][0];
    fork
      pkt(0);
      pkt(1);
      send(0, 4, 18'h30400, 3'd0);
      send(1, 4, 18'h30400, 3'd0);
    join
    repeat (6) @(negedge clk);
    chk("wl_cnt", 32'(lg_n[0][0] - b0), 4);
    chk("wn_cnt", 32'(lg_n[1][0] - b1), 4);
    for (int k = 0; k < 4; k++) begin
      chk("wl_dat", 32'(lg_d[0][0][(b0 + k) % 16]), 32'(e_wl[k]));
      chk("wl_lk",  32'(lg_k[0][0][(b0 + k) % 16]), 32'(k_wl[k]));
      chk("wn_dat", 32'(lg_d[1][0][(b1 + k) % 16]), 32'(e_wn[k]));
      chk("wn_lk",  32'(lg_k[1][0][(b1 + k) % 16]), 0);
    end

    // Parallel grants on outputs 4 and 2.
    fork
      send(0, 0, 18'h30004, 3'd4);
      send(0, 3, 18'h30302, 3'd2);
      send(1, 0, 18'h30004, 3'd4);
      send(1, 3, 18'h30302, 3'd2);
      begin
        @(negedge clk);
        chk("par_l", 32'(o_req[0]), 32'h14);
        chk("par_n", 32'(o_req[1]), 32'h14);
      end
    join
    repeat (6) @(negedge clk);

    // Reset while output 3 holds O_REQ; input 2 targets dest 5.
    snk_en = 1'b0;
    for (int m = 0; m < 2; m++) begin
      s_data[m][2] = 18'h30205;
      s_dest[m][2] = 3'd5;
      s_req[m][2]  = 1'b1;
    end
    fork
      send(0, 1, 18'h30111, 3'd3);
      send(1, 1, 18'h30111, 3'd3);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst", 32'(o_req[0][3]), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mr_req_l", 32'(o_req[0]), 0);
        chk("mr_req_n", 32'(o_req[1]), 0);
        chk("mr_ack",   32'(s_ack[0]), 0);
        chk("mr_dat",   32'(o_dat[0][3]), 0);
      end
    join
    snk_en = 1'b1;

    // Pointer back at NUM_PORTS-1: input 1 beats input 3.
    b0 = lg_n[0][3];
    d5 = 0;
    fork
      send(0, 1, 18'h30A01, 3'd3);
      send(0, 3, 18'h30A03, 3'd3);
      send(1, 1, 18'h30A01, 3'd3);
      send(1, 3, 18'h30A03, 3'd3);
      begin
        for (int t = 0; t < 30; t++) begin
          @(negedge clk);
          if (s_ack[0][2] !== 1'b0 || s_ack[1][2] !== 1'b0) d5++;
        end
      end
    join
    chk("d5_ack", 32'(d5), 0);
    chk("ptr_1st", 32'(lg_d[0][3][b0 % 16]), 32'h30A01);
    chk("ptr_2nd", 32'(lg_d[0][3][(b0 + 1) % 16]), 32'h30A03);
    s_req[0][2] = 1'b0;
    s_req[1][2] = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
